stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
- Parametrised N-channel streaming multiplexer; successor to the plain 4:1 combinational selector.
- Each input is a valid/ready stream. The block selects one channel per cycle, either round-robin or by a fixed `sel`, and forwards the word through a registered output stage with its source channel tag.
- Sits between multiple producers and a single shared consumer; throughput is one word per cycle.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- WIDTH, 8, data bits per channel.
- CH_W, $clog2(NUM_CH), width of channel index (derived; do not override).

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_last  input  NUM_CH  per-channel end-of-packet marker.
- in_ready  output  NUM_CH  per-channel ready (combinational).
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  CH_W  channel used when mode=1.
- out_data  output  WIDTH  registered data.
- out_ch  output  CH_W  registered source channel index.
- out_last  output  1  registered last flag.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_ch=0, out_last=0, rr pointer=0, lock cleared. A word in flight is dropped; no in_ready is asserted while rst=1.
- Output stage: single register.
  - can_accept = !out_valid || out_ready.
  - Transfer on channel i occurs when in_valid[i] && in_ready[i] at the clock edge.
  - Output appears the next cycle. Latency is 1 cycle; back-to-back transfers are allowed when out_ready is held high.
- Handshake rules:
  - in_ready[i] = grant[i] && can_accept. At most one bit is set.
  - in_ready does not depend on in_valid of the same channel, except through the grant.
  - out_data, out_ch and out_last are held stable while out_valid && !out_ready.
  - out_valid drops only after a transfer with no new accept in the same cycle.
- Round-robin (mode=0):
  - Priority starts at the rr pointer and searches upward modulo NUM_CH.
  - The grant goes to the first channel with in_valid set.
  - After a transfer from channel k, pointer = (k+1) mod NUM_CH. The pointer is unchanged if no transfer occurs.
  - No valid inputs: no grant, all in_ready=0.
- Fixed (mode=1):
  - grant = one-hot(sel) when sel < NUM_CH; otherwise no grant.
  - The rr pointer is frozen.
- Mode/sel changes: take effect in the same cycle's grant computation. The output register is unaffected.
- Simultaneous accept and drain: when out_valid && out_ready and a new transfer occurs, the register loads the new word and out_valid stays 1.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN.
- Defined:
  - After a transfer with in_last[k]=0, the grant is locked to channel k until the transfer carrying in_last[k]=1.
  - This applies in both modes; the lock overrides the rr pointer and sel.
  - The rr pointer advances only on the last beat.
  - Reset clears the lock.
- Undefined:
  - in_last is passed through to out_last only.
  - Arbitration is per word, with no locking.

Decomposition:
- Package stream_mux_pkg:
  - mode constants MODE_RR=1'b0, MODE_FIXED=1'b1;
  - function for the one-hot-to-index conversion.
- Sub-module rr_arbiter (NUM_CH):
  - inputs: request vector and pointer;
  - output: one-hot grant;
  - purely combinational.
- stream_mux_rr holds the pointer, lock state and output register.

Test Plan:
- Reset with in_valid=4'b1111 held: all outputs 0 and in_ready=0 while rst=1. After release with mode=0 and out_ready=1, out_ch follows 0,1,2,3,0 on consecutive cycles, 1 cycle after each accept.
- mode=0, in_valid=4'b1010, out_ready=1: grants alternate ch1, ch3, ch1. out_data matches in_data for those slices (e.g. ch1=8'hA1, ch3=8'hC3).
- Backpressure: out_ready=0 for 3 cycles after one accept. out_valid=1, out_data/out_ch stay stable, in_ready=0. Releasing out_ready gives a transfer plus a new accept in the same cycle, with out_valid remaining 1.
- mode=1, sel=2, in_valid=4'b1111: only in_ready[2] toggles. Switching to sel=0 moves the grant on the next cycle's compute. For NUM_CH=3, sel=3 gives no grant.
- STREAM_MUX_LOCK_EN: ch0 sends a 3-beat packet (last on beat 3) with ch1 valid throughout. Output is ch0,ch0,ch0,ch1. Without the macro the output is ch0,ch1,ch0,ch1,ch0.
- Async reset asserted mid-stream between clock edges: out_valid goes to 0 immediately, without waiting for a clock edge. After release, round-robin restarts from ch0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr streaming multiplexer.
package stream_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Widest channel vector the index helper accepts; callers zero-extend to this.
    localparam int MAX_CH = 16;

    function automatic logic [3:0] onehot_to_idx(input logic [MAX_CH-1:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (onehot[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping modulo NUM_CH.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant
);

    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    logic            found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int o = 0; o < NUM_CH; o++) begin
            sum = {1'b0, ptr} + (CH_W+1)'(o);
            if (sum >= (CH_W+1)'(NUM_CH)) begin
                sum = sum - (CH_W+1)'(NUM_CH);
            end
            idx = sum[CH_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin or fixed select and a registered output.
// Define STREAM_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [CH_W-1:0]         sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  out_data_reg;
    logic [CH_W-1:0]   out_ch_reg;
    logic              out_last_reg;
    logic              out_valid_reg;
    logic [CH_W-1:0]   ptr_reg;

    logic [NUM_CH-1:0] rr_grant;
    logic [NUM_CH-1:0] fixed_grant;
    logic [NUM_CH-1:0] base_grant;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] xfer_vec;
    logic              can_accept;
    logic              xfer;
    logic              xfer_last;
    logic [CH_W-1:0]   xfer_ch;
    logic [WIDTH-1:0]  xfer_data;
    logic              ptr_advance;
    logic [CH_W-1:0]   ptr_next;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr_reg),
        .grant (rr_grant)
    );

    // An out-of-range sel matches no channel, so no grant is produced.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fixed
            assign fixed_grant[gi] = (sel == CH_W'(gi));
        end
    endgenerate

    assign base_grant = (mode == MODE_FIXED) ? fixed_grant : rr_grant;

`ifdef STREAM_MUX_LOCK_EN
    logic              locked_reg;
    logic [CH_W-1:0]   lock_ch_reg;
    logic [NUM_CH-1:0] lock_grant;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lock
            assign lock_grant[gi] = (lock_ch_reg == CH_W'(gi));
        end
    endgenerate

    assign grant       = locked_reg ? lock_grant : base_grant;
    assign ptr_advance = xfer && xfer_last && (mode == MODE_RR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_reg  <= 1'b0;
            lock_ch_reg <= '0;
        end else if (xfer) begin
            locked_reg  <= !xfer_last;
            lock_ch_reg <= xfer_ch;
        end
    end
`else
    assign grant       = base_grant;
    assign ptr_advance = xfer && (mode == MODE_RR);
`endif

    assign can_accept = !out_valid_reg || out_ready;
    // rst gates in_ready directly: the empty output stage would otherwise look ready.
    assign in_ready   = grant & {NUM_CH{can_accept && !rst}};
    assign xfer_vec   = in_valid & in_ready;
    assign xfer       = |xfer_vec;
    assign xfer_last  = |(xfer_vec & in_last);
    assign xfer_ch    = CH_W'(onehot_to_idx(MAX_CH'(xfer_vec)));
    assign ptr_next   = (xfer_ch == CH_W'(NUM_CH-1)) ? '0 : xfer_ch + CH_W'(1);

    always_comb begin
        xfer_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (xfer_vec[i]) begin
                xfer_data = xfer_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (xfer) begin
            out_data_reg  <= xfer_data;
            out_ch_reg    <= xfer_ch;
            out_last_reg  <= xfer_last;
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (ptr_advance) begin
            ptr_reg <= ptr_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_last  = out_last_reg;
    assign out_valid = out_valid_reg;

endmodule
